// File: rtl/riscv_pkg.sv
// Shared integer-core constants and the debug register-port state type.
package riscv_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned AddressWidth = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } dbg_state_e;

endpackage

// File: rtl/regfile_dbg_port.sv
// Debug-side initiator for the integer register file: one GPR read or write per
// request, executed only while the core is halted, with a bounded wait for halt.
module regfile_dbg_port #(
  parameter int unsigned DataWidth     = riscv_pkg::DataWidth,
  parameter int unsigned AddressWidth  = riscv_pkg::AddressWidth,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dbg_req_valid_i,
  output logic                    dbg_req_ready_o,
  input  logic                    dbg_req_we_i,
  input  logic [AddressWidth-1:0] dbg_req_addr_i,
  input  logic [DataWidth-1:0]    dbg_req_wdata_i,
  output logic                    dbg_rsp_valid_o,
  input  logic                    dbg_rsp_ready_i,
  output logic [DataWidth-1:0]    dbg_rsp_rdata_o,
  output logic                    dbg_rsp_err_o,
  input  logic                    core_halted_i,
  input  logic                    core_wr_en_i,
  input  logic [AddressWidth-1:0] core_rd_addr_i,
  input  logic [DataWidth-1:0]    core_rd_data_i,
  input  logic [AddressWidth-1:0] core_rs1_addr_i,
  output logic                    rf_wr_en_o,
  output logic [AddressWidth-1:0] rf_rd_addr_o,
  output logic [DataWidth-1:0]    rf_rd_data_o,
  output logic [AddressWidth-1:0] rf_rs1_addr_o,
  input  logic [DataWidth-1:0]    rf_rs1_data_i
);

  import riscv_pkg::*;

  // Counter is at least one bit wide so the wait-forever build still elaborates.
  localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  dbg_state_e              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    exec_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The regfile is only safe to touch when the core is halted and not retiring a write.
  assign exec_ok = core_halted_i && !core_wr_en_i;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    dbg_req_ready_o = 1'b0;
    dbg_rsp_valid_o = 1'b0;
    rf_wr_en_o      = core_wr_en_i;
    rf_rd_addr_o    = core_rd_addr_i;
    rf_rd_data_o    = core_rd_data_i;
    rf_rs1_addr_o   = core_rs1_addr_i;

    unique case (state_q)
      IDLE: begin
        dbg_req_ready_o = !rst_i;
        if (dbg_req_valid_i) begin
          we_d    = dbg_req_we_i;
          addr_d  = dbg_req_addr_i;
          wdata_d = dbg_req_wdata_i;
          cnt_d   = '0;
          state_d = exec_ok ? EXEC : WAIT;
        end
      end
      WAIT: begin
        if (exec_ok) begin
          state_d = EXEC;
        end else if ((TimeoutCycles != 0) && (cnt_q == CntLast)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      EXEC: begin
        // x0 is hard-wired, so a write to it is refused and reported.
        rf_wr_en_o    = we_q && (addr_q != '0) && !rst_i;
        rf_rd_addr_o  = addr_q;
        rf_rd_data_o  = wdata_q;
        rf_rs1_addr_o = addr_q;
        if (we_q) begin
          rdata_d = '0;
          err_d   = (addr_q == '0);
        end else begin
          rdata_d = rf_rs1_data_i;
          err_d   = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        dbg_rsp_valid_o = 1'b1;
        if (dbg_rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_rsp_rdata_o = rdata_q;
  assign dbg_rsp_err_o   = err_q;

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Self-checking bench for regfile_dbg_port: a behavioural regfile sits behind the
// port and a golden register array predicts every debug response.
module tb_regfile_dbg_port;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          dbg_req_valid_i = 1'b0, dbg_req_ready_o, dbg_req_we_i = 1'b0;
  logic [AW-1:0] dbg_req_addr_i = '0;
  logic [DW-1:0] dbg_req_wdata_i = '0;
  logic          dbg_rsp_valid_o, dbg_rsp_ready_i = 1'b0, dbg_rsp_err_o;
  logic [DW-1:0] dbg_rsp_rdata_o;
  logic          core_halted_i = 1'b0, core_wr_en_i = 1'b0;
  logic [AW-1:0] core_rd_addr_i = '0, core_rs1_addr_i = '0;
  logic [DW-1:0] core_rd_data_i = '0;
  logic          rf_wr_en_o;
  logic [AW-1:0] rf_rd_addr_o, rf_rs1_addr_o;
  logic [DW-1:0] rf_rd_data_o, rf_rs1_data_i;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] rf_mem [32];
  logic [DW-1:0] golden [32];

  typedef struct packed {
    logic          acc_ready;
    logic          x_wr_en;
    logic [AW-1:0] x_wr_addr;
    logic [DW-1:0] x_wr_data;
    logic [AW-1:0] x_rs1;
    logic          x_valid;
    logic          r_valid;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic          r_wr_en;
    logic          idle_ready;
  } obs_t;

  regfile_dbg_port #(.DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dbg_req_valid_i(dbg_req_valid_i), .dbg_req_ready_o(dbg_req_ready_o),
    .dbg_req_we_i(dbg_req_we_i), .dbg_req_addr_i(dbg_req_addr_i), .dbg_req_wdata_i(dbg_req_wdata_i),
    .dbg_rsp_valid_o(dbg_rsp_valid_o), .dbg_rsp_ready_i(dbg_rsp_ready_i),
    .dbg_rsp_rdata_o(dbg_rsp_rdata_o), .dbg_rsp_err_o(dbg_rsp_err_o),
    .core_halted_i(core_halted_i), .core_wr_en_i(core_wr_en_i),
    .core_rd_addr_i(core_rd_addr_i), .core_rd_data_i(core_rd_data_i), .core_rs1_addr_i(core_rs1_addr_i),
    .rf_wr_en_o(rf_wr_en_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_o(rf_rd_data_o),
    .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs1_data_i(rf_rs1_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural regfile: x0 reads as zero, writes land on the rising edge.
  always @(posedge clk_i) begin
    if (rf_wr_en_o && rf_rd_addr_o != '0) rf_mem[rf_rd_addr_o] <= rf_rd_data_o;
  end
  assign rf_rs1_data_i = (rf_rs1_addr_o == '0) ? '0 : rf_mem[rf_rs1_addr_o];

  // Issue one request with the core halted and capture what is seen in each phase.
  task automatic halted_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               output obs_t o);
    @(negedge clk_i);
    core_halted_i = 1'b1; core_wr_en_i = 1'b0; dbg_rsp_ready_i = 1'b1;
    dbg_req_valid_i = 1'b1; dbg_req_we_i = we; dbg_req_addr_i = addr; dbg_req_wdata_i = wdata;
    #1 o.acc_ready = dbg_req_ready_o;
    @(negedge clk_i);
    o.x_wr_en = rf_wr_en_o; o.x_wr_addr = rf_rd_addr_o; o.x_wr_data = rf_rd_data_o;
    o.x_rs1 = rf_rs1_addr_o; o.x_valid = dbg_rsp_valid_o;
    dbg_req_valid_i = 1'b0;
    @(negedge clk_i);
    o.r_valid = dbg_rsp_valid_o; o.r_rdata = dbg_rsp_rdata_o; o.r_err = dbg_rsp_err_o; o.r_wr_en = rf_wr_en_o;
    @(negedge clk_i);
    o.idle_ready = dbg_req_ready_o;
  endtask

  task automatic test_reset;
    @(negedge clk_i);
    @(negedge clk_i);
    n_cmp++; if (dbg_req_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", dbg_req_ready_o); end
    n_cmp++; if (dbg_rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", dbg_rsp_valid_o); end
    n_cmp++; if (dbg_rsp_rdata_o !== '0 || dbg_rsp_err_o !== 1'b0) begin n_err++;
      $display("FAIL reset_rsp got rdata=%h err=%b exp 0/0", dbg_rsp_rdata_o, dbg_rsp_err_o); end
    rst_i = 1'b0;
    #1;
    n_cmp++; if (dbg_req_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b exp 1", dbg_req_ready_o); end
  endtask

  task automatic test_passthrough;
    logic [DW-1:0] d;
    logic [AW-1:0] rs1;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk_i);
      d = 32'($urandom); rs1 = 5'($urandom);
      core_wr_en_i = 1'b1; core_rd_addr_i = 5'(i); core_rd_data_i = d; core_rs1_addr_i = rs1;
      golden[i] = d;
      #1;
      n_cmp++; if (rf_wr_en_o !== 1'b1 || rf_rd_addr_o !== 5'(i) || rf_rd_data_o !== d || rf_rs1_addr_o !== rs1) begin
        n_err++; $display("FAIL passthrough got we=%b a=%0d d=%h rs1=%0d exp 1/%0d/%h/%0d",
                          rf_wr_en_o, rf_rd_addr_o, rf_rd_data_o, rf_rs1_addr_o, i, d, rs1); end
    end
    @(negedge clk_i);
    core_wr_en_i = 1'b0;
  endtask

  task automatic test_write_x5;
    obs_t o;
    halted_access(1'b1, 5'd5, 32'hDEADBEEF, o);
    n_cmp++; if (o.x_wr_en !== 1'b1 || o.x_wr_addr !== 5'd5 || o.x_wr_data !== 32'hDEADBEEF) begin n_err++;
      $display("FAIL x5_exec got we=%b a=%0d d=%h exp 1/5/deadbeef", o.x_wr_en, o.x_wr_addr, o.x_wr_data); end
    n_cmp++; if (o.r_valid !== 1'b1 || o.r_err !== 1'b0 || o.r_wr_en !== 1'b0) begin n_err++;
      $display("FAIL x5_rsp got valid=%b err=%b we=%b exp 1/0/0", o.r_valid, o.r_err, o.r_wr_en); end
    golden[5] = 32'hDEADBEEF;
    halted_access(1'b0, 5'd5, 32'h0, o);
    n_cmp++; if (o.r_valid !== 1'b1 || o.r_rdata !== golden[5]) begin n_err++;
      $display("FAIL x5_readback got valid=%b rdata=%h exp 1/%h", o.r_valid, o.r_rdata, golden[5]); end
  endtask

  task automatic test_write_x0;
    obs_t o;
    halted_access(1'b1, 5'd0, 32'h1234, o);
    n_cmp++; if (o.x_wr_en !== 1'b0) begin n_err++; $display("FAIL x0_wr_en got %b exp 0", o.x_wr_en); end
    n_cmp++; if (o.r_valid !== 1'b1 || o.r_err !== 1'b1 || o.r_rdata !== '0) begin n_err++;
      $display("FAIL x0_rsp got valid=%b err=%b rdata=%h exp 1/1/0", o.r_valid, o.r_err, o.r_rdata); end
    halted_access(1'b0, 5'd0, 32'h0, o);
    n_cmp++; if (o.r_rdata !== '0 || o.r_err !== 1'b0) begin n_err++;
      $display("FAIL x0_read got rdata=%h err=%b exp 0/0", o.r_rdata, o.r_err); end
  endtask

  task automatic test_timeout;
    int first = -1;
    @(negedge clk_i);
    core_halted_i = 1'b0; core_wr_en_i = 1'b0; dbg_rsp_ready_i = 1'b1;
    dbg_req_valid_i = 1'b1; dbg_req_we_i = 1'b0; dbg_req_addr_i = 5'd3;
    core_rs1_addr_i = 5'($urandom);
    for (int k = 1; k <= 20 && first < 0; k++) begin
      @(negedge clk_i);
      dbg_req_valid_i = 1'b0;
      n_cmp++; if (rf_rs1_addr_o !== core_rs1_addr_i) begin n_err++;
        $display("FAIL timeout_rs1_override cyc %0d got %0d exp %0d", k, rf_rs1_addr_o, core_rs1_addr_i); end
      if (dbg_rsp_valid_o === 1'b1) begin
        first = k;
        n_cmp++; if (dbg_rsp_err_o !== 1'b1 || dbg_rsp_rdata_o !== '0) begin n_err++;
          $display("FAIL timeout_rsp got err=%b rdata=%h exp 1/0", dbg_rsp_err_o, dbg_rsp_rdata_o); end
      end
      core_rs1_addr_i = 5'($urandom);
    end
    n_cmp++; if (first != 9) begin n_err++; $display("FAIL timeout_latency got %0d exp 9", first); end
  endtask

  task automatic test_halt_late;
    int first = -1;
    logic [DW-1:0] v;
    v = 32'($urandom);
    @(negedge clk_i);
    core_halted_i = 1'b0; core_wr_en_i = 1'b0; dbg_rsp_ready_i = 1'b1; core_rs1_addr_i = 5'd1;
    dbg_req_valid_i = 1'b1; dbg_req_we_i = 1'b0; dbg_req_addr_i = 5'd7;
    for (int k = 1; k <= 20 && first < 0; k++) begin
      @(negedge clk_i);
      dbg_req_valid_i = 1'b0;
      if (core_wr_en_i) begin
        n_cmp++; if (rf_wr_en_o !== 1'b1 || rf_rd_addr_o !== 5'd7 || rf_rs1_addr_o !== 5'd1) begin n_err++;
          $display("FAIL late_core_write got we=%b a=%0d rs1=%0d exp 1/7/1", rf_wr_en_o, rf_rd_addr_o, rf_rs1_addr_o); end
      end
      if (dbg_rsp_valid_o === 1'b1) begin
        first = k;
        n_cmp++; if (dbg_rsp_rdata_o !== golden[7] || dbg_rsp_err_o !== 1'b0) begin n_err++;
          $display("FAIL late_rdata got %h err=%b exp %h/0", dbg_rsp_rdata_o, dbg_rsp_err_o, golden[7]); end
      end
      if (k == 3) begin
        core_halted_i = 1'b1; core_wr_en_i = 1'b1; core_rd_addr_i = 5'd7; core_rd_data_i = v;
        golden[7] = v;
      end
      if (k == 4) core_wr_en_i = 1'b0;
    end
    n_cmp++; if (first != 6) begin n_err++; $display("FAIL late_latency got %0d exp 6", first); end
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] a, b;
    a = 5'($urandom_range(1, 31)); b = 5'($urandom_range(1, 31));
    @(negedge clk_i);
    core_halted_i = 1'b1; core_wr_en_i = 1'b0; dbg_rsp_ready_i = 1'b0;
    dbg_req_valid_i = 1'b1; dbg_req_we_i = 1'b0; dbg_req_addr_i = a;
    @(negedge clk_i);
    dbg_req_addr_i = b;
    n_cmp++; if (dbg_req_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_exec_ready got %b exp 0", dbg_req_ready_o); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_cmp++; if (dbg_rsp_valid_o !== 1'b1 || dbg_rsp_rdata_o !== golden[a] || dbg_rsp_err_o !== 1'b0 || dbg_req_ready_o !== 1'b0) begin
        n_err++; $display("FAIL bp_hold cyc %0d got valid=%b rdata=%h err=%b ready=%b exp 1/%h/0/0",
                          i, dbg_rsp_valid_o, dbg_rsp_rdata_o, dbg_rsp_err_o, dbg_req_ready_o, golden[a]); end
    end
    dbg_rsp_ready_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (dbg_req_ready_o !== 1'b1 || dbg_rsp_valid_o !== 1'b0) begin n_err++;
      $display("FAIL bp_after_handshake got ready=%b valid=%b exp 1/0", dbg_req_ready_o, dbg_rsp_valid_o); end
    @(negedge clk_i);
    dbg_req_valid_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (dbg_rsp_valid_o !== 1'b1 || dbg_rsp_rdata_o !== golden[b]) begin n_err++;
      $display("FAIL bp_second got valid=%b rdata=%h exp 1/%h", dbg_rsp_valid_o, dbg_rsp_rdata_o, golden[b]); end
  endtask

  task automatic test_reset_mid;
    obs_t o;
    // Reset while waiting for halt.
    @(negedge clk_i);
    core_halted_i = 1'b0; dbg_rsp_ready_i = 1'b1;
    dbg_req_valid_i = 1'b1; dbg_req_we_i = 1'b1; dbg_req_addr_i = 5'd9; dbg_req_wdata_i = 32'($urandom);
    @(negedge clk_i);
    dbg_req_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (dbg_rsp_valid_o !== 1'b0 || dbg_rsp_err_o !== 1'b0 || dbg_req_ready_o !== 1'b0) begin n_err++;
      $display("FAIL rst_wait got valid=%b err=%b ready=%b exp 0/0/0", dbg_rsp_valid_o, dbg_rsp_err_o, dbg_req_ready_o); end
    rst_i = 1'b0; core_halted_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_cmp++; if (dbg_rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_wait_no_rsp got %b exp 0", dbg_rsp_valid_o); end
    end
    halted_access(1'b0, 5'd9, 32'h0, o);
    n_cmp++; if (o.r_rdata !== golden[9]) begin n_err++; $display("FAIL rst_wait_x9 got %h exp %h", o.r_rdata, golden[9]); end
    // Reset during the EXEC cycle of a write.
    @(negedge clk_i);
    dbg_req_valid_i = 1'b1; dbg_req_we_i = 1'b1; dbg_req_addr_i = 5'd9; dbg_req_wdata_i = ~golden[9];
    @(negedge clk_i);
    dbg_req_valid_i = 1'b0; rst_i = 1'b1;
    #1;
    n_cmp++; if (rf_wr_en_o !== 1'b0) begin n_err++; $display("FAIL rst_exec_wr_en got %b exp 0", rf_wr_en_o); end
    @(negedge clk_i);
    n_cmp++; if (dbg_rsp_valid_o !== 1'b0 || dbg_rsp_rdata_o !== '0 || dbg_rsp_err_o !== 1'b0) begin n_err++;
      $display("FAIL rst_exec_out got valid=%b rdata=%h err=%b exp 0/0/0", dbg_rsp_valid_o, dbg_rsp_rdata_o, dbg_rsp_err_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (dbg_rsp_valid_o !== 1'b0 || dbg_req_ready_o !== 1'b1) begin n_err++;
      $display("FAIL rst_exec_idle got valid=%b ready=%b exp 0/1", dbg_rsp_valid_o, dbg_req_ready_o); end
    halted_access(1'b0, 5'd9, 32'h0, o);
    n_cmp++; if (o.r_rdata !== golden[9]) begin n_err++; $display("FAIL rst_exec_x9 got %h exp %h", o.r_rdata, golden[9]); end
  endtask

  task automatic test_random;
    obs_t o;
    logic we;
    logic [AW-1:0] a;
    logic [DW-1:0] d, exp_rdata;
    logic exp_wr;
    for (int n = 0; n < 24; n++) begin
      we = 1'($urandom); a = 5'($urandom); d = 32'($urandom);
      exp_wr = we && (a != '0);
      exp_rdata = (we || a == '0) ? '0 : golden[a];
      halted_access(we, a, d, o);
      n_cmp++; if (o.acc_ready !== 1'b1 || o.x_valid !== 1'b0 || o.idle_ready !== 1'b1) begin n_err++;
        $display("FAIL rnd_handshake #%0d got acc=%b xv=%b idle=%b exp 1/0/1", n, o.acc_ready, o.x_valid, o.idle_ready); end
      n_cmp++; if (o.x_wr_en !== exp_wr || (exp_wr && (o.x_wr_addr !== a || o.x_wr_data !== d)) || (!we && o.x_rs1 !== a)) begin
        n_err++; $display("FAIL rnd_exec #%0d we=%b a=%0d got wr=%b wa=%0d wd=%h rs1=%0d exp wr=%b",
                          n, we, a, o.x_wr_en, o.x_wr_addr, o.x_wr_data, o.x_rs1, exp_wr); end
      n_cmp++; if (o.r_valid !== 1'b1 || o.r_rdata !== exp_rdata || o.r_err !== (we && a == '0)) begin n_err++;
        $display("FAIL rnd_rsp #%0d we=%b a=%0d got v=%b rd=%h err=%b exp 1/%h/%b",
                 n, we, a, o.r_valid, o.r_rdata, o.r_err, exp_rdata, we && a == '0); end
      if (exp_wr) golden[a] = d;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) golden[i] = '0;
    test_reset();
    test_passthrough();
    test_write_x5();
    test_write_x0();
    test_timeout();
    test_halt_late();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
